// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan monitor:
// segment patterns, digit codes and frame FSM states.
package seg7_pkg;

  localparam int NDIG  = 4;
  localparam int VAL_W = 14;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_INVALID = 4'hD;
  localparam logic [3:0] CODE_DASH    = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT
  } frame_st_t;

  // acc*10 + weight(code); non-numeric codes weigh zero
  function automatic logic [VAL_W-1:0] mac10(
    input logic [VAL_W-1:0] acc,
    input logic [3:0]       code
  );
    logic [VAL_W-1:0] w;
    w = (code <= 4'd9) ? {{(VAL_W-4){1'b0}}, code} : '0;
    return (acc << 3) + (acc << 1) + w;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-high 7-bit segment pattern to 4-bit digit code.
// Pure combinational; also reused by display-side benches.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code
);

  always_comb begin
    o_code = CODE_INVALID;
    unique case (i_pat)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_DASH:  o_code = CODE_DASH;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-seg bus: deglitch,
// decode and reassemble the displayed 0..9999 value.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg,
  input  logic [3:0]       an,
  output logic [VAL_W-1:0] value,
  output logic             valid,
  output logic             show_error,
  output logic             bad_frame,
  output logic             stale
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic [6:0]       r_pseg;
  logic [3:0]       r_pan;
  logic [CW-1:0]    r_cnt;
  logic             r_armed;
  logic [3:0]       r_digit [NDIG];
  logic [3:0]       r_seen;
  logic             r_bad;
  logic [TW-1:0]    r_tmo;
  frame_st_t        r_state;
  logic [VAL_W-1:0] r_value;
  logic             r_err;
  logic             r_emit_bad;
  logic             r_stale;

  logic             w_onehot;
  logic             w_same;
  logic             w_accept;
  logic [3:0]       w_code;
  logic [3:0]       w_seen_nx;
  logic             w_bad_nx;
  logic [3:0]       w_dig_nx [NDIG];
  logic             w_done;
  logic             w_tmo;
  logic [VAL_W-1:0] w_sum;
  logic             w_dash;
  frame_st_t        w_state_nx;

  seg7_pattern_decode u_dec (
    .i_pat  (r_seg),
    .o_code (w_code)
  );

  assign w_onehot  = (r_an != 4'h0) && ((r_an & (r_an - 4'h1)) == 4'h0);
  assign w_same    = {r_an, r_seg} == {r_pan, r_pseg};
  assign w_accept  = w_onehot && w_same && r_armed && (r_cnt == CNT_HIT);
  assign w_seen_nx = r_seen | (w_accept ? r_an : 4'h0);
  assign w_bad_nx  = r_bad | (w_accept && (w_code == CODE_INVALID));
  assign w_done    = w_accept && (w_seen_nx == 4'hF);
  assign w_tmo     = !w_accept && (r_tmo == TMO_MAX);

  // Combiner works on post-accept digits so the last digit counts
  always_comb begin
    w_sum  = '0;
    w_dash = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_dig_nx[i] = (w_accept && r_an[i]) ? w_code : r_digit[i];
      w_sum  = mac10(w_sum, w_dig_nx[i]);
      w_dash = w_dash | (w_dig_nx[i] == CODE_DASH);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg  <= '0;
      r_an   <= '0;
      r_pseg <= '0;
      r_pan  <= '0;
    end else begin
      r_seg  <= SEG_ACTIVE_LOW ? ~seg : seg;
      r_an   <= AN_ACTIVE_LOW ? ~an : an;
      r_pseg <= r_seg;
      r_pan  <= r_an;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      if (!w_onehot || !w_same)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      if (!w_same)
        r_armed <= 1'b1;
      else if (w_accept)
        r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NDIG; i++)
        r_digit[i] <= '0;
      r_seen <= '0;
      r_bad  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++)
        r_digit[i] <= w_dig_nx[i];
      if (w_done || w_tmo) begin
        r_seen <= '0;
        r_bad  <= 1'b0;
      end else begin
        r_seen <= w_seen_nx;
        r_bad  <= w_bad_nx;
      end
      if (w_accept)
        r_tmo <= '0;
      else if (r_tmo != TMO_MAX)
        r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value    <= '0;
      r_err      <= 1'b0;
      r_emit_bad <= 1'b0;
      r_stale    <= 1'b1;
    end else begin
      if (w_done) begin
        r_emit_bad <= w_bad_nx;
        if (!w_bad_nx) begin
          r_value <= w_sum;
          r_err   <= w_dash;
          r_stale <= 1'b0;
        end
      end
      if (w_tmo)
        r_stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nx = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_done)
          w_state_nx = ST_EMIT;
        else if (w_tmo)
          w_state_nx = ST_IDLE;
      end
      ST_EMIT: begin
        w_state_nx = w_accept ? ST_COLLECT : ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign value      = r_value;
  assign show_error = r_err;
  assign stale      = r_stale;
  assign valid      = (r_state == ST_EMIT) && !r_emit_bad;
  assign bad_frame  = (r_state == ST_EMIT) && r_emit_bad;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random frames
// compared against a decimal reference model.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [13:0] value;
  logic        valid;
  logic        show_error;
  logic        bad_frame;
  logic        stale;

  int n_chk = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_bad = 0;
  int n_both = 0;

  logic [6:0] pat_of [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] bad_pat [0:2] = '{7'h55, 7'h01, 7'h7E};
  localparam logic [6:0] DASH = 7'h40;

  seg7_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .an         (an),
    .value      (value),
    .valid      (valid),
    .show_error (show_error),
    .bad_frame  (bad_frame),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) n_valid++;
    if (bad_frame) n_bad++;
    if (valid && bad_frame) n_both++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic show(input int idx, input logic [6:0] pat, input int n);
    an  = ~(4'b0001 << idx);
    seg = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an  = 4'hF;
    seg = 7'h7F;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0,
                       input int n);
    show(3, p3, n);
    show(2, p2, n);
    show(1, p1, n);
    show(0, p0, n);
  endtask

  initial begin
    int v0, b0, r, w, dw;
    bit is_bad, is_dash;
    int exp_val, exp_err;
    logic [6:0] p [4];

    @(negedge clk);
    idle(3);
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_err", show_error, 0);
    check("rst_bad", bad_frame, 0);
    check("rst_stale", stale, 1);
    reset = 1'b1;
    idle(2);

    frame(pat_of[1], pat_of[2], pat_of[3], pat_of[4], 8);
    idle(4);
    check("f1234_valid_cnt", n_valid, 1);
    check("f1234_bad_cnt", n_bad, 0);
    check("f1234_value", value, 1234);
    check("f1234_err", show_error, 0);
    check("f1234_stale", stale, 0);

    frame(DASH, DASH, DASH, DASH, 8);
    idle(4);
    check("dash_valid_cnt", n_valid, 2);
    check("dash_value", value, 0);
    check("dash_err", show_error, 1);
    frame(pat_of[0], pat_of[0], pat_of[5], pat_of[7], 8);
    idle(4);
    check("f57_valid_cnt", n_valid, 3);
    check("f57_value", value, 57);
    check("f57_err", show_error, 0);

    frame(pat_of[1], 7'h55, pat_of[3], pat_of[4], 8);
    idle(4);
    check("inv_bad_cnt", n_bad, 1);
    check("inv_valid_cnt", n_valid, 3);
    check("inv_value_hold", value, 57);

    for (int i = 3; i >= 0; i--) begin
      logic [6:0] g;
      g = (i == 3) ? pat_of[2] : (i == 2) ? pat_of[0] :
          (i == 1) ? pat_of[2] : pat_of[6];
      show(i, g, 2);
      show(i, 7'h7F, 3);
      show(i, g, 5);
    end
    idle(4);
    check("glitch_valid_cnt", n_valid, 4);
    check("glitch_value", value, 2026);

    show(3, pat_of[5], 6);
    show(2, pat_of[5], 6);
    idle(80);
    check("tmo_stale", stale, 1);
    check("tmo_valid_cnt", n_valid, 4);
    check("tmo_bad_cnt", n_bad, 1);
    check("tmo_value_hold", value, 2026);
    show(1, pat_of[9], 6);
    show(0, pat_of[9], 6);
    idle(80);
    check("tmo_dropped", n_valid, 4);
    frame(pat_of[9], pat_of[9], pat_of[9], pat_of[9], 8);
    idle(4);
    check("f9999_valid_cnt", n_valid, 5);
    check("f9999_value", value, 9999);
    check("f9999_stale", stale, 0);

    show(3, pat_of[7], 6);
    show(2, pat_of[7], 6);
    show(1, pat_of[7], 6);
    reset = 1'b0;
    idle(3);
    check("mrst_stale", stale, 1);
    check("mrst_value", value, 0);
    reset = 1'b1;
    idle(2);
    v0 = n_valid;
    frame(pat_of[0], pat_of[0], pat_of[0], pat_of[1], 8);
    idle(4);
    check("mrst_valid_cnt", n_valid - v0, 1);
    check("mrst_value1", value, 1);
    exp_val = 1;
    exp_err = 0;

    for (int f = 0; f < 24; f++) begin
      v0 = n_valid;
      b0 = n_bad;
      is_bad = 1'b0;
      is_dash = 1'b0;
      w = 0;
      for (int i = 3; i >= 0; i--) begin
        r = int'($urandom_range(0, 13));
        w = w * 10;
        if (r < 10) begin
          p[i] = pat_of[r];
          w = w + r;
        end else if (r < 12) begin
          p[i] = DASH;
          is_dash = 1'b1;
        end else if (r == 12) begin
          p[i] = 7'h00;
        end else begin
          p[i] = bad_pat[$urandom_range(0, 2)];
          is_bad = 1'b1;
        end
      end
      dw = int'($urandom_range(4, 9));
      frame(p[3], p[2], p[1], p[0], dw);
      idle(3);
      if (!is_bad) begin
        exp_val = w;
        exp_err = int'(is_dash);
      end
      check("rnd_valid_cnt", n_valid - v0, is_bad ? 0 : 1);
      check("rnd_bad_cnt", n_bad - b0, is_bad ? 1 : 0);
      check("rnd_value", value, exp_val);
      check("rnd_err", show_error, exp_err);
    end

    check("valid_bad_overlap", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
